// File: rtl/selector_pkg.sv
// selector_pkg: shared sizes and FSM state type for the round-robin selector arbiter.
package selector_pkg;
    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/selector_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set request at or above ptr, wrapping.
module rr_pick
    import selector_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [SEL_W-1:0]   win_o,
    output logic               any_o
);
    always_comb begin
        win_o = '0;
        any_o = |req_i;
        // Scan from the farthest offset down so the nearest request to ptr is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_i[ptr_i + SEL_W'(k)]) win_o = ptr_i + SEL_W'(k);
    end
endmodule

// File: rtl/selector_rr_arbiter.sv
// selector_rr_arbiter: round-robin owner of a shared 8:1 selector with registered B[A] output.
// Define SELECTOR_ARB_TIMEOUT_EN to force-release grants held for TIMEOUT_CYCLES cycles.
module selector_rr_arbiter
    import selector_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic [NUM_REQ-1:0] B,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [SEL_W-1:0]   A,
    output logic               res,
    output logic               timeout
);
    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [SEL_W-1:0]   a_q;
    logic [SEL_W-1:0]   ptr_q;
    logic               res_q;
    logic               timeout_q;
    logic [SEL_W-1:0]   win;
    logic               any;
    logic               rel_user;
    logic               force_rel;
    logic               rel;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    rr_pick u_pick (.req_i(req), .ptr_i(ptr_q), .win_o(win), .any_o(any));

    assign rel_user = done | ~req[a_q];

`ifdef SELECTOR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    // Owner-initiated release on the limit edge wins over the forced one.
    assign force_rel = (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !rel_user;
    always_ff @(posedge clk)
        cnt_q <= (rst || state_q == IDLE || rel) ? '0 : cnt_q + CW'(1);
`else
    assign force_rel = 1'b0;
`endif

    assign rel = rel_user | force_rel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            a_q       <= '0;
            ptr_q     <= '0;
            res_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (state_q == IDLE) begin
            res_q     <= 1'b0;
            timeout_q <= 1'b0;
            if (any) begin
                state_q <= GRANT;
                a_q     <= win;
                gnt_q   <= NUM_REQ'(1) << win;
            end
        end else if (rel) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            a_q       <= '0;
            res_q     <= 1'b0;
            ptr_q     <= a_q + SEL_W'(1);
            timeout_q <= force_rel;
        end else begin
            res_q     <= B[a_q];
            timeout_q <= 1'b0;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == GRANT);
    assign A         = a_q;
    assign res       = res_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_selector_rr_arbiter.sv
// tb_selector_rr_arbiter: directed checks of grant order, wrap, res path, release and reset.
module tb_selector_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] B = '0;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] A;
    logic       res;
    logic       timeout;
    int tests = 0;
    int fails = 0;

    selector_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .B(B),
        .gnt(gnt), .gnt_valid(gnt_valid), .A(A), .res(res), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tests++; if (gnt !== 8'h00) begin fails++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        tests++; if (A !== 3'd0) begin fails++; $display("FAIL reset_A: got %0d want 0", A); end
        tests++; if (res !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL reset_res_timeout: got %b%b want 00", res, timeout); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        req = 8'b0000_0101;
        tick();
        tests++; if (gnt !== 8'h01 || A !== 3'd0 || gnt_valid !== 1'b1) begin fails++; $display("FAIL basic_first: got gnt=%h A=%0d v=%b want 01 0 1", gnt, A, gnt_valid); end
        req = 8'b0000_0111;
        tick();
        tests++; if (gnt !== 8'h01 || A !== 3'd0) begin fails++; $display("FAIL basic_hold: got gnt=%h A=%0d want 01 0", gnt, A); end
        done = 1'b1;
        req = 8'b0000_0101;
        tick();
        done = 1'b0;
        tests++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin fails++; $display("FAIL basic_release: got gnt=%h v=%b want 00 0", gnt, gnt_valid); end
        tick();
        tests++; if (gnt !== 8'h04 || A !== 3'd2) begin fails++; $display("FAIL basic_second: got gnt=%h A=%0d want 04 2", gnt, A); end
        req = 8'h00;
        tick(2);
    endtask

    task automatic test_wrap;
        req = 8'b0100_0000;
        tick();
        tests++; if (A !== 3'd6) begin fails++; $display("FAIL wrap_a6: got %0d want 6", A); end
        done = 1'b1;
        req = 8'h00;
        tick();
        done = 1'b0;
        req = 8'b1000_0001;
        tick();
        tests++; if (gnt !== 8'h80 || A !== 3'd7) begin fails++; $display("FAIL wrap_a7: got gnt=%h A=%0d want 80 7", gnt, A); end
        done = 1'b1;
        tick();
        done = 1'b0;
        tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL wrap_gap: got v=%b want 0", gnt_valid); end
        tick();
        tests++; if (gnt !== 8'h01 || A !== 3'd0) begin fails++; $display("FAIL wrap_to0: got gnt=%h A=%0d want 01 0", gnt, A); end
        req = 8'h00;
        tick(2);
    endtask

    task automatic test_res;
        B = 8'b1111_1110;
        req = 8'h01;
        tick(2);
        tests++; if (A !== 3'd0 || res !== 1'b0) begin fails++; $display("FAIL res_b0: got A=%0d res=%b want 0 0", A, res); end
        req = 8'h00;
        tick(2);
        req = 8'h02;
        tick();
        tests++; if (A !== 3'd1 || res !== 1'b0) begin fails++; $display("FAIL res_first_cycle: got A=%0d res=%b want 1 0", A, res); end
        tick();
        tests++; if (res !== 1'b1) begin fails++; $display("FAIL res_b1: got %b want 1", res); end
        req = 8'h00;
        tick();
        tests++; if (res !== 1'b0 || gnt_valid !== 1'b0) begin fails++; $display("FAIL res_idle: got res=%b v=%b want 0 0", res, gnt_valid); end
        tick();
    endtask

    task automatic test_withdraw;
        req = 8'b0001_0000;
        tick();
        tests++; if (A !== 3'd4) begin fails++; $display("FAIL withdraw_grant: got %0d want 4", A); end
        req = 8'h00;
        tick();
        tests++; if (gnt !== 8'h00) begin fails++; $display("FAIL withdraw_release: got %h want 00", gnt); end
        req = 8'b0010_0000;
        tick();
        tests++; if (A !== 3'd5) begin fails++; $display("FAIL withdraw_a5: got %0d want 5", A); end
        done = 1'b1;
        req = 8'hFF;
        tick();
        done = 1'b0;
        tests++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin fails++; $display("FAIL done_req_gap: got gnt=%h v=%b want 00 0", gnt, gnt_valid); end
        tick();
        tests++; if (gnt !== 8'h40 || A !== 3'd6) begin fails++; $display("FAIL done_req_next: got gnt=%h A=%0d want 40 6", gnt, A); end
        done = 1'b1;
        req = 8'h00;
        tick();
        done = 1'b0;
        tick();
        tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL done_idle: got v=%b want 0", gnt_valid); end
    endtask

    task automatic test_timeout;
        bit tbad = 1'b0;
        req = 8'h01;
        tick();
        tests++; if (A !== 3'd0 || gnt_valid !== 1'b1) begin fails++; $display("FAIL hold_grant: got A=%0d v=%b want 0 1", A, gnt_valid); end
`ifdef SELECTOR_ARB_TIMEOUT_EN
        tick(3);
        tests++; if (gnt_valid !== 1'b1 || timeout !== 1'b0) begin fails++; $display("FAIL to_cycle4: got v=%b to=%b want 1 0", gnt_valid, timeout); end
        tick();
        tests++; if (gnt_valid !== 1'b0 || timeout !== 1'b1) begin fails++; $display("FAIL to_forced: got v=%b to=%b want 0 1", gnt_valid, timeout); end
        tick();
        tests++; if (timeout !== 1'b0 || gnt_valid !== 1'b1 || A !== 3'd0) begin fails++; $display("FAIL to_pulse_end: got to=%b v=%b A=%0d want 0 1 0", timeout, gnt_valid, A); end
        tick(3);
        done = 1'b1;
        tick();
        done = 1'b0;
        tests++; if (timeout !== 1'b0 || gnt_valid !== 1'b0) begin fails++; $display("FAIL to_precedence: got to=%b v=%b want 0 0", timeout, gnt_valid); end
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (timeout !== 1'b0) tbad = 1'b1;
        end
        tests++; if (gnt_valid !== 1'b1 || A !== 3'd0 || tbad) begin fails++; $display("FAIL no_timeout_hold: got v=%b A=%0d to_seen=%b want 1 0 0", gnt_valid, A, tbad); end
`endif
        req = 8'h00;
        tick(2);
    endtask

    task automatic test_reset_mid;
        req = 8'b0000_1000;
        tick();
        tests++; if (A !== 3'd3) begin fails++; $display("FAIL mid_grant: got %0d want 3", A); end
        rst = 1'b1;
        tick();
        tests++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || A !== 3'd0 || res !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL mid_reset: got gnt=%h v=%b A=%0d res=%b to=%b want all 0", gnt, gnt_valid, A, res, timeout); end
        rst = 1'b0;
        req = 8'h81;
        tick();
        tests++; if (A !== 3'd0) begin fails++; $display("FAIL mid_ptr0: got %0d want 0", A); end
        req = 8'h00;
        tick(2);
        req = 8'h80;
        tick();
        tests++; if (A !== 3'd7 || gnt !== 8'h80) begin fails++; $display("FAIL mid_a7: got A=%0d gnt=%h want 7 80", A, gnt); end
        req = 8'h00;
        tick();
    endtask

    initial begin
        tick(2);
        test_reset();
        test_basic();
        test_wrap();
        test_res();
        test_withdraw();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
